// File: rtl/light_source_sel.sv
// Debounced N-way colour source selector feeding a fixed-depth output pipeline.
// Optional feature macro: LIGHT_SEL_BLANK_EN (insert BLANK dark cycles after each commit).
module light_source_sel #(
    parameter int WIDTH   = 24,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int HOLD    = 4,
    parameter int DELAY   = 5,
    parameter int BLANK   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*WIDTH-1:0]   src,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       enable,
    output logic [WIDTH-1:0]           light,
    output logic [SEL_W-1:0]           active_sel,
    output logic                       switching
);

    typedef enum logic [1:0] {
        S_STABLE = 2'd0,
        S_PEND   = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [SEL_W:0]   NUM_SRC_X = (SEL_W + 1)'(NUM_SRC);

`ifdef LIGHT_SEL_BLANK_EN
    localparam int BCNT_W = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'(BLANK - 1);
    localparam state_t COMMIT_ST = (BLANK > 0) ? S_BLANK : S_STABLE;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
`else
    localparam state_t COMMIT_ST = S_STABLE;
`endif

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   cand, cand_nxt;
    logic [SEL_W-1:0]   active_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               valid_req;
    logic [WIDTH-1:0]   stage0_d;
    logic [WIDTH-1:0]   src_arr [NUM_SRC];
    logic [WIDTH-1:0]   stage   [DELAY];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_arr[k] = src[k*WIDTH +: WIDTH];
    end

    // An out-of-range index behaves like re-selecting the committed source.
    assign valid_req = ({1'b0, sel} < NUM_SRC_X) && (sel != active_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_STABLE;
            cand       <= '0;
            cnt        <= '0;
            active_sel <= '0;
`ifdef LIGHT_SEL_BLANK_EN
            bcnt       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            active_sel <= active_nxt;
`ifdef LIGHT_SEL_BLANK_EN
            bcnt       <= bcnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        active_nxt = active_sel;
`ifdef LIGHT_SEL_BLANK_EN
        bcnt_nxt   = bcnt;
`endif
        case (state)
            S_STABLE: begin
                if (valid_req) begin
                    if (HOLD == 1) begin
                        active_nxt = sel;
                        state_nxt  = COMMIT_ST;
                        cnt_nxt    = '0;
`ifdef LIGHT_SEL_BLANK_EN
                        bcnt_nxt   = '0;
`endif
                    end else begin
                        state_nxt = S_PEND;
                        cand_nxt  = sel;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_PEND: begin
                if (!valid_req) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = '0;
                end else if (sel == cand) begin
                    // Commit on the edge where the count would reach HOLD.
                    if (cnt == HOLD_LAST) begin
                        active_nxt = cand;
                        state_nxt  = COMMIT_ST;
                        cnt_nxt    = '0;
`ifdef LIGHT_SEL_BLANK_EN
                        bcnt_nxt   = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cand_nxt = sel;
                    cnt_nxt  = CNT_W'(1);
                end
            end
`ifdef LIGHT_SEL_BLANK_EN
            S_BLANK: begin
                if (bcnt == BLANK_LAST) begin
                    state_nxt = S_STABLE;
                    bcnt_nxt  = '0;
                end else begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end
`endif
            default: state_nxt = S_STABLE;
        endcase
    end

    always_comb begin
        switching = (state != S_STABLE);
`ifdef LIGHT_SEL_BLANK_EN
        stage0_d = (enable && (state != S_BLANK)) ? src_arr[active_sel] : '0;
`else
        stage0_d = enable ? src_arr[active_sel] : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DELAY; k++) stage[k] <= '0;
        end else begin
            stage[0] <= stage0_d;
            for (int k = 1; k < DELAY; k++) stage[k] <= stage[k-1];
        end
    end

    assign light = stage[DELAY-1];

endmodule

// File: tb/tb_light_source_sel.sv
// Randomised and directed bench for light_source_sel against a run-length debounce model.
module tb_light_source_sel;

    localparam int W     = 24;
    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int HOLD  = 4;
    localparam int DELAY = 5;
    localparam int BLANK = 2;
`ifdef LIGHT_SEL_BLANK_EN
    localparam int BLANK_CYC = BLANK;
`else
    localparam int BLANK_CYC = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  src;
    logic [SW-1:0]   sel;
    logic            enable;
    logic [W-1:0]    light;
    logic [SW-1:0]   active_sel;
    logic            switching;

    logic [3*W-1:0]  src3;
    logic [1:0]      sel3;
    logic [W-1:0]    light3;
    logic [1:0]      active3;
    logic            switching3;

    int errors = 0;
    int checks = 0;

    int mActive, mRunVal, mRunLen, mBlankLeft;
    logic [W-1:0] mPipe[$];

    light_source_sel #(.WIDTH(W), .NUM_SRC(N), .HOLD(HOLD), .DELAY(DELAY), .BLANK(BLANK)) u_dut (
        .clk(clk), .rst_n(rst_n), .src(src), .sel(sel), .enable(enable),
        .light(light), .active_sel(active_sel), .switching(switching)
    );

    light_source_sel #(.WIDTH(W), .NUM_SRC(3), .HOLD(2), .DELAY(1), .BLANK(BLANK)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .src(src3), .sel(sel3), .enable(enable),
        .light(light3), .active_sel(active3), .switching(switching3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [W-1:0] srcWord(input int k);
        return src[k*W +: W];
    endfunction

    function automatic logic [W-1:0] expLight();
        return mPipe[DELAY-1];
    endfunction

    function automatic logic expSwitch();
        return (mRunLen > 0) || (mBlankLeft > 0);
    endfunction

    task automatic modelReset();
        mActive = 0; mRunVal = -1; mRunLen = 0; mBlankLeft = 0;
        mPipe = {};
        for (int i = 0; i < DELAY; i++) mPipe.push_back('0);
    endtask

    // A source is committed once it has been requested on HOLD consecutive edges.
    task automatic tick(input logic [SW-1:0] s, input logic en);
        int si;
        logic [W-1:0] w0;
        sel = s; enable = en; si = int'(s);
        w0 = (mBlankLeft > 0 || !en) ? '0 : srcWord(mActive);
        if (mBlankLeft > 0) begin
            mBlankLeft--;
        end else if (si < N && si != mActive) begin
            if (si == mRunVal) mRunLen++;
            else begin mRunVal = si; mRunLen = 1; end
            if (mRunLen == HOLD) begin
                mActive = si; mRunLen = 0; mRunVal = -1; mBlankLeft = BLANK_CYC;
            end
        end else begin
            mRunLen = 0; mRunVal = -1;
        end
        mPipe.push_front(w0);
        void'(mPipe.pop_back());
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; sel = '0; sel3 = '0; enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        src = '1; sel = '0; enable = 1'b1; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (light !== '0) begin errors++; $display("[TB] FAIL reset light: got %h expected 000000", light); end
        if (active_sel !== '0) begin errors++; $display("[TB] FAIL reset active_sel: got %0d expected 0", active_sel); end
        if (switching !== 1'b0) begin errors++; $display("[TB] FAIL reset switching: got %b expected 0", switching); end
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        repeat (5) tick(2'd0, 1'b1);
        checks++;
        if (light !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL reset_fill light: got %h expected ffffff", light); end
        repeat (2) tick(2'd3, 1'b1);
        checks++;
        if (switching !== 1'b1) begin errors++; $display("[TB] FAIL reset_pend switching: got %b expected 1", switching); end
        rst_n = 1'b0;
        #2;
        checks += 3;
        if (light !== '0) begin errors++; $display("[TB] FAIL async_reset light: got %h expected 000000", light); end
        if (active_sel !== '0) begin errors++; $display("[TB] FAIL async_reset active_sel: got %0d expected 0", active_sel); end
        if (switching !== 1'b0) begin errors++; $display("[TB] FAIL async_reset switching: got %b expected 0", switching); end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_switch();
        int lightEdge;
        doReset();
        src = {24'h123456, 24'h00FF00, 24'hABCDEF, 24'h0000FF};
        repeat (6) tick(2'd0, 1'b1);
        lightEdge = 9 + BLANK_CYC;
        for (int i = 1; i <= 12; i++) begin
            tick(2'd2, 1'b1);
            checks += 3;
            if (light !== expLight()) begin errors++; $display("[TB] FAIL switch light @%0d: got %h expected %h", i, light, expLight()); end
            if (active_sel !== SW'(mActive)) begin errors++; $display("[TB] FAIL switch active_sel @%0d: got %0d expected %0d", i, active_sel, mActive); end
            if (switching !== expSwitch()) begin errors++; $display("[TB] FAIL switch switching @%0d: got %b expected %b", i, switching, expSwitch()); end
            if (i == 1) begin
                checks++;
                if (switching !== 1'b1) begin errors++; $display("[TB] FAIL switch_start switching: got %b expected 1", switching); end
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (active_sel !== ((i == 4) ? 2'd2 : 2'd0)) begin errors++; $display("[TB] FAIL switch_commit active_sel @%0d: got %0d", i, active_sel); end
            end
            if (i == lightEdge - 1) begin
                checks++;
                if (light !== ((BLANK_CYC > 0) ? 24'h000000 : 24'h0000FF)) begin errors++; $display("[TB] FAIL switch_prelight light: got %h", light); end
            end
            if (i == lightEdge) begin
                checks++;
                if (light !== 24'h00FF00) begin errors++; $display("[TB] FAIL switch_light light: got %h expected 00ff00", light); end
            end
        end
    endtask

    task automatic test_glitch();
        logic [SW-1:0] pat [11];
        doReset();
        src = {24'h123456, 24'h00FF00, 24'hABCDEF, 24'h0000FF};
        repeat (6) tick(2'd0, 1'b1);
        for (int i = 0; i < 11; i++) pat[i] = (i < 3) ? 2'd2 : 2'd0;
        for (int i = 0; i < 11; i++) begin
            tick(pat[i], 1'b1);
            checks += 3;
            if (light !== 24'h0000FF) begin errors++; $display("[TB] FAIL glitch light @%0d: got %h expected 0000ff", i, light); end
            if (active_sel !== 2'd0) begin errors++; $display("[TB] FAIL glitch active_sel @%0d: got %0d expected 0", i, active_sel); end
            if (switching !== expSwitch()) begin errors++; $display("[TB] FAIL glitch switching @%0d: got %b expected %b", i, switching, expSwitch()); end
        end
        checks++;
        if (switching !== 1'b0) begin errors++; $display("[TB] FAIL glitch_end switching: got %b expected 0", switching); end
    endtask

    task automatic test_retarget();
        doReset();
        for (int k = 0; k < N; k++) src[k*W +: W] = W'($urandom);
        repeat (2) tick(2'd0, 1'b1);
        repeat (2) tick(2'd1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick(2'd3, 1'b1);
            checks += 2;
            if (active_sel !== ((i >= 4) ? 2'd3 : 2'd0)) begin errors++; $display("[TB] FAIL retarget active_sel @%0d: got %0d", i, active_sel); end
            if (switching !== expSwitch()) begin errors++; $display("[TB] FAIL retarget switching @%0d: got %b expected %b", i, switching, expSwitch()); end
        end
        repeat (2) tick(2'd2, 1'b1);
        checks++;
        if (switching !== 1'b1) begin errors++; $display("[TB] FAIL retarget_pend switching: got %b expected 1", switching); end
        tick(2'd3, 1'b1);
        checks += 2;
        if (switching !== 1'b0) begin errors++; $display("[TB] FAIL retarget_cancel switching: got %b expected 0", switching); end
        if (active_sel !== 2'd3) begin errors++; $display("[TB] FAIL retarget_cancel active_sel: got %0d expected 3", active_sel); end
    endtask

    task automatic test_out_of_range();
        doReset();
        src3 = {24'h333333, 24'h222222, 24'h111111};
        tick(2'd0, 1'b1);
        checks++;
        if (light3 !== 24'h111111) begin errors++; $display("[TB] FAIL oob light3: got %h expected 111111", light3); end
        sel3 = 2'd1;
        tick(2'd0, 1'b1);
        checks++;
        if (switching3 !== 1'b1) begin errors++; $display("[TB] FAIL oob_pend switching3: got %b expected 1", switching3); end
        sel3 = 2'd3;
        tick(2'd0, 1'b1);
        checks += 2;
        if (switching3 !== 1'b0) begin errors++; $display("[TB] FAIL oob_cancel switching3: got %b expected 0", switching3); end
        if (active3 !== 2'd0) begin errors++; $display("[TB] FAIL oob_cancel active3: got %0d expected 0", active3); end
        sel3 = 2'd1;
        tick(2'd0, 1'b1);
        checks++;
        if (active3 !== 2'd0) begin errors++; $display("[TB] FAIL oob_hold active3: got %0d expected 0", active3); end
        tick(2'd0, 1'b1);
        checks++;
        if (active3 !== 2'd1) begin errors++; $display("[TB] FAIL oob_commit active3: got %0d expected 1", active3); end
    endtask

    task automatic test_enable();
        int zeros;
        doReset();
        for (int k = 0; k < N; k++) src[k*W +: W] = W'($urandom) | 24'h1;
        repeat (6) tick(2'd0, 1'b1);
        zeros = 0;
        for (int i = 0; i < 12; i++) begin
            tick(2'd0, (i == 0 || i == 1) ? 1'b0 : 1'b1);
            if (light == '0) zeros++;
            checks += 2;
            if (light !== expLight()) begin errors++; $display("[TB] FAIL enable light @%0d: got %h expected %h", i, light, expLight()); end
            if (active_sel !== 2'd0) begin errors++; $display("[TB] FAIL enable active_sel @%0d: got %0d expected 0", i, active_sel); end
        end
        checks++;
        if (zeros != 2) begin errors++; $display("[TB] FAIL enable_zero_count: got %0d expected 2", zeros); end
    endtask

    task automatic test_random();
        logic [SW-1:0] rs;
        logic en;
        doReset();
        rs = '0;
        for (int k = 0; k < N; k++) src[k*W +: W] = W'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) src[$urandom_range(0, N-1)*W +: W] = W'($urandom);
            if ($urandom_range(0, 3) == 0) rs = SW'($urandom_range(0, N-1));
            en = ($urandom_range(0, 9) != 0);
            tick(rs, en);
            checks += 3;
            if (light !== expLight()) begin errors++; $display("[TB] FAIL random light @%0d: got %h expected %h", i, light, expLight()); end
            if (active_sel !== SW'(mActive)) begin errors++; $display("[TB] FAIL random active_sel @%0d: got %0d expected %0d", i, active_sel, mActive); end
            if (switching !== expSwitch()) begin errors++; $display("[TB] FAIL random switching @%0d: got %b expected %b", i, switching, expSwitch()); end
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = '0; sel3 = '0; enable = 1'b1; src = '0; src3 = '0;
        modelReset();
        test_reset();
        test_switch();
        test_glitch();
        test_retarget();
        test_out_of_range();
        test_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
